// File: rtl/line_stepper.sv
// line_stepper
// Bresenham stepper for one octant-normalised line. It accepts a pair of
// endpoints from the point swapper and emits one screen-space pixel per
// handshake, undoing the swap on the way out.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       line handshake (in_ready high only in IDLE)
//   sx_0, sy_0, sx_1, sy_1    normalised endpoints, point 0 is the start
//   line_octant               octant code from the point swapper
//   pix_valid / pix_ready     pixel handshake
//   pixel_x, pixel_y          screen-space pixel coordinate
//   pix_last                  final pixel of the line (qualified by pix_valid)
//   busy                      high while a line is being stepped
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for a line, in_ready=1, no pixel presented
// ST_RUN   | presenting cur_x/cur_y, stepping on each pixel handshake

module line_stepper (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [9:0] sx_0,
   input  logic [9:0] sy_0,
   input  logic [9:0] sx_1,
   input  logic [9:0] sy_1,
   input  logic [2:0] line_octant,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       pix_last,
   output logic       busy
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic               state_q,  state_d;
   logic [9:0]         x_end_q,  x_end_d;
   logic [9:0]         dx_q,     dx_d;
   logic [9:0]         dy_q,     dy_d;
   logic               neg_q,    neg_d;
   logic               trans_q,  trans_d;
   logic [9:0]         cur_x_q,  cur_x_d;
   logic [9:0]         cur_y_q,  cur_y_d;
   logic signed [12:0] err_q,    err_d;

   logic               accept;
   logic               step;
   logic               at_end;
   logic               x_reversed;
   logic [9:0]         acc_dx;
   logic [9:0]         acc_dy;
   logic signed [12:0] err_init;
   logic signed [12:0] inc_flat;
   logic signed [12:0] inc_diag;

   // Octant bit 2 only selects which half-plane the swapper folded from;
   // the stepping itself does not depend on it.
   logic unused_octant_bit;
   assign unused_octant_bit = line_octant[2];

   assign accept     = (state_q == ST_IDLE) && in_valid;
   assign at_end     = (cur_x_q == x_end_q);
   assign step       = (state_q == ST_RUN) && pix_ready;
   assign x_reversed = (sx_1 < sx_0);

   // A reversed x range collapses to the start point: dx is zero and the end
   // column is pinned to sx_0 so pix_last fires on the first pixel.
   assign acc_dx = x_reversed ? 10'd0 : (sx_1 - sx_0);
   assign acc_dy = (sy_1 >= sy_0) ? (sy_1 - sy_0) : (sy_0 - sy_1);

   // 2*dy - dx spans [-1023, 2046]; the running error stays within
   // [-2*dx, 2*dy], so 13 signed bits never overflow.
   assign err_init = $signed({2'b00, acc_dy, 1'b0}) - $signed({3'b000, acc_dx});
   assign inc_flat = $signed({2'b00, dy_q, 1'b0});
   assign inc_diag = $signed({2'b00, dy_q, 1'b0}) - $signed({2'b00, dx_q, 1'b0});

   always_comb begin
      state_d = state_q;
      x_end_d = x_end_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      neg_d   = neg_q;
      trans_d = trans_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               x_end_d = x_reversed ? sx_0 : sx_1;
               dx_d    = acc_dx;
               dy_d    = acc_dy;
               neg_d   = line_octant[1];
               trans_d = ~(line_octant[1] ^ line_octant[0]);
               cur_x_d = sx_0;
               cur_y_d = sy_0;
               err_d   = err_init;
            end
         end
         ST_RUN: begin
            if (step) begin
               if (at_end) begin
                  state_d = ST_IDLE;
               end else begin
                  cur_x_d = cur_x_q + 10'd1;
                  if (err_q > 13'sd0) begin
                     cur_y_d = neg_q ? (cur_y_q - 10'd1) : (cur_y_q + 10'd1);
                     err_d   = err_q + inc_diag;
                  end else begin
                     err_d   = err_q + inc_flat;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x_end_q <= 10'd0;
         dx_q    <= 10'd0;
         dy_q    <= 10'd0;
         neg_q   <= 1'b0;
         trans_q <= 1'b0;
         cur_x_q <= 10'd0;
         cur_y_q <= 10'd0;
         err_q   <= 13'sd0;
      end else begin
         state_q <= state_d;
         x_end_q <= x_end_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         neg_q   <= neg_d;
         trans_q <= trans_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign pix_valid = (state_q == ST_RUN);
   assign busy      = (state_q == ST_RUN);
   assign pix_last  = (state_q == ST_RUN) && at_end;
   assign pixel_x   = trans_q ? cur_y_q : cur_x_q;
   assign pixel_y   = trans_q ? cur_x_q : cur_y_q;

endmodule

// File: tb/tb_line_stepper.sv
// Testbench for line_stepper. Expected pixels come from the closed-form
// Bresenham row offset k(i) = floor((2*dy*i + dx - 1) / (2*dx)).

module tb_line_stepper;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [9:0] sx_0 = '0, sy_0 = '0, sx_1 = '0, sy_1 = '0;
   logic [2:0] line_octant = '0;
   logic       pix_valid;
   logic       pix_ready = 1'b0;
   logic [9:0] pixel_x, pixel_y;
   logic       pix_last;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int exp_x[$];
   int exp_y[$];

   line_stepper dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sx_0(sx_0), .sy_0(sy_0), .sx_1(sx_1), .sy_1(sy_1),
      .line_octant(line_octant), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_last(pix_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic build_exp(input int x0, input int y0, input int x1, input int y1,
                            input int oct);
      int dx, dy, k, px, py;
      bit neg, trans;
      exp_x.delete();
      exp_y.delete();
      neg   = oct[1];
      trans = (oct[1] == oct[0]);
      dx    = (x1 < x0) ? 0 : x1 - x0;
      dy    = (y1 > y0) ? y1 - y0 : y0 - y1;
      for (int i = 0; i <= dx; i++) begin
         k  = (dx == 0) ? 0 : (2 * dy * i + dx - 1) / (2 * dx);
         px = x0 + i;
         py = neg ? (y0 - k) : (y0 + k);
         py = ((py % 1024) + 1024) % 1024;
         if (trans) begin
            exp_x.push_back(py);
            exp_y.push_back(px);
         end else begin
            exp_x.push_back(px);
            exp_y.push_back(py);
         end
      end
   endtask

   // mode 0: pix_ready always 1, 1: toggle 1/0, 2: random ready and junk inputs
   task automatic run_line(input string name, input int x0, input int y0,
                           input int x1, input int y1, input int oct, input int mode);
      int  idx, cyc, n;
      bit  done, stalled, rdy, tog;
      logic [9:0] hx, hy;
      logic       hl;
      build_exp(x0, y0, x1, y1, oct);
      n = exp_x.size();
      @(negedge clk);
      sx_0 = 10'(x0); sy_0 = 10'(y0); sx_1 = 10'(x1); sy_1 = 10'(y1);
      line_octant = 3'(oct);
      in_valid = 1'b1;
      pix_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || pix_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s accept: in_ready=%b pix_valid=%b expected 1/0", name, in_ready, pix_valid);
      end
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      in_valid = 1'b0;
      idx = 0; done = 0; stalled = 0; tog = 1;
      while (!done && cyc < 400) begin
         vectors++;
         if (pix_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s run flags: valid=%b busy=%b in_ready=%b expected 1/1/0",
                     name, pix_valid, busy, in_ready);
         end
         if (stalled) begin
            vectors++;
            if (pixel_x !== hx || pixel_y !== hy || pix_last !== hl) begin
               miscompares++;
               $display("FAIL %s stall hold: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                        name, pixel_x, pixel_y, pix_last, hx, hy, hl);
            end
         end
         case (mode)
            0:       rdy = 1;
            1:       begin rdy = tog; tog = !tog; end
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         pix_ready = rdy;
         if (mode == 2) begin
            in_valid = 1'($urandom_range(0, 1));
            sx_0 = 10'($urandom); sy_0 = 10'($urandom);
            sx_1 = 10'($urandom); sy_1 = 10'($urandom);
            line_octant = 3'($urandom);
         end
         if (rdy) begin
            vectors++;
            if (pixel_x !== 10'(exp_x[idx]) || pixel_y !== 10'(exp_y[idx]) ||
                pix_last !== (idx == n - 1)) begin
               miscompares++;
               $display("FAIL %s pixel %0d: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                        name, idx, pixel_x, pixel_y, pix_last, exp_x[idx], exp_y[idx], idx == n - 1);
            end
            if (idx == n - 1) done = 1;
            idx++;
            stalled = 0;
         end else begin
            hx = pixel_x; hy = pixel_y; hl = pix_last;
            stalled = 1;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      pix_ready = 1'b0;
      in_valid  = 1'b0;
      if (!done) begin
         miscompares++;
         $display("FAIL %s timeout: %0d of %0d pixels seen", name, idx, n);
      end
      vectors++;
      if (in_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s return to idle: in_ready=%b valid=%b busy=%b expected 1/0/0",
                  name, in_ready, pix_valid, busy);
      end
      if (mode != 2) begin
         vectors++;
         if (cyc != ((mode == 0) ? n + 1 : 2 * n)) begin
            miscompares++;
            $display("FAIL %s cycles: got %0d expected %0d", name, cyc,
                     (mode == 0) ? n + 1 : 2 * n);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if (in_ready !== 1'b1 || pix_valid !== 1'b0 || pix_last !== 1'b0 || busy !== 1'b0 ||
          pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
         miscompares++;
         $display("FAIL reset state: rdy=%b val=%b last=%b busy=%b x=%0d y=%0d",
                  in_ready, pix_valid, pix_last, busy, pixel_x, pixel_y);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_line("shallow", 0, 0, 5, 2, 1, 0);
      run_line("transposed", 0, 0, 3, 1, 0, 0);
      run_line("negative", 0, 5, 4, 3, 2, 0);
      run_line("point", 7, 9, 7, 9, 1, 0);
      run_line("reversed", 20, 30, 12, 33, 1, 0);
   endtask

   task automatic test_backpressure();
      run_line("toggle", 0, 0, 5, 2, 1, 1);
   endtask

   task automatic test_reset_midline();
      @(negedge clk);
      sx_0 = 10'd0; sy_0 = 10'd0; sx_1 = 10'd5; sy_1 = 10'd2;
      line_octant = 3'd1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (pix_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || pix_last !== 1'b0 ||
          pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
         miscompares++;
         $display("FAIL midline reset: val=%b rdy=%b busy=%b last=%b x=%0d y=%0d",
                  pix_valid, in_ready, busy, pix_last, pixel_x, pixel_y);
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (pix_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset hold: pix_valid=%b expected 0", pix_valid);
      end
      pix_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_line("after reset", 100, 200, 110, 196, 2, 0);
   endtask

   task automatic test_random();
      int dx, dy, oct, x0, y0, y1;
      for (int t = 0; t < 30; t++) begin
         dx  = $urandom_range(0, 30);
         dy  = $urandom_range(0, dx);
         oct = $urandom_range(0, 7);
         x0  = $urandom_range(0, 1023 - dx);
         if (oct[1]) begin
            y0 = $urandom_range(dy, 1023);
            y1 = y0 - dy;
         end else begin
            y0 = $urandom_range(0, 1023 - dy);
            y1 = y0 + dy;
         end
         run_line("random", x0, y0, x0 + dx, y1, oct, 2);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midline();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/line_stepper.md
LINE_STEPPER -- requirements
Module: line_stepper

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  endpoint set on sx_0..sy_1/line_octant is valid.
REQ-004 in_ready  output  1  block can accept a line; high only in IDLE.
REQ-005 sx_0, sy_0, sx_1, sy_1  input  10 each  octant-normalised endpoints from point swapper; point 0 is the start, point 1 is the end.
REQ-006 line_octant  input  3  octant code produced by point swapper.
REQ-007 pix_valid  output  1  pixel_x/pixel_y hold a valid pixel.
REQ-008 pix_ready  input  1  downstream accepts the pixel this cycle.
REQ-009 pixel_x, pixel_y  output  10 each  screen-space pixel coordinate, swap undone.
REQ-010 pix_last  output  1  the current pixel is the final pixel of the line; qualified by pix_valid.
REQ-011 busy  output  1  high in RUN.

Function
REQ-012 States: IDLE, RUN; no other states are reachable.
REQ-013 IDLE: in_ready=1, pix_valid=0; in_valid=1 latches all inputs and moves to RUN the next cycle.
REQ-014 On accept: dx = sx_1 - sx_0 (10-bit unsigned); dy = |sy_1 - sy_0| (10-bit unsigned); err = 2*dy - dx in 13-bit signed; cur_x = sx_0, cur_y = sy_0.
REQ-015 Decode: negative = line_octant[1]; transposed = line_octant[1] XNOR line_octant[0], true for codes 0, 3, 4 and 7.
REQ-016 If sx_1 < sx_0 at accept, dx is forced to 0, so exactly one pixel (sx_0, sy_0) is emitted.
REQ-017 RUN: pix_valid=1 every cycle; pix_last = (cur_x == latched sx_1).
REQ-018 Output mapping, not transposed: pixel_x = cur_x, pixel_y = cur_y.
REQ-019 Output mapping, transposed: pixel_x = cur_y, pixel_y = cur_x.
REQ-020 Step on pix_valid and pix_ready, when pix_last=0: cur_x += 1.
REQ-021 In that step, if err > 0: cur_y moves by 1 (minus 1 if negative, plus 1 otherwise) and err += 2*dy - 2*dx.
REQ-022 In that step, if err <= 0: cur_y is unchanged and err += 2*dy.
REQ-023 On pix_valid and pix_ready with pix_last=1: return to IDLE next cycle, so in_ready rises one cycle after the last handshake.
REQ-024 Stall: when pix_ready=0, pixel_x, pixel_y, pix_last, err and cur_* hold unchanged.
REQ-025 First pixel is valid the cycle after accept; with pix_ready held high, one pixel is emitted per cycle.
REQ-026 A line of N pixels therefore takes N+1 cycles from accept to next in_ready.
REQ-027 err shall never overflow its 13-bit signed range for any 10-bit inputs.
REQ-028 in_valid during RUN is ignored; no input is latched.
REQ-029 cur_y arithmetic wraps modulo 1024; no clamping is applied (upstream guarantees on-screen endpoints).

Reset
REQ-030 rst asserted forces the state to IDLE immediately, asynchronously.
REQ-031 During reset: in_ready=1, pix_valid=0, pix_last=0, busy=0, pixel_x=0, pixel_y=0, err=0.
REQ-032 Reset mid-line discards the line; no further pixels of that line appear after reset deasserts.
REQ-033 The first cycle after deassertion can accept a new line.

Verification
REQ-034 Shallow line: octant 1, (0,0)->(5,2), pix_ready=1 -> pixels (0,0)(1,0)(2,1)(3,1)(4,2)(5,2) on consecutive cycles, pix_last only on (5,2), in_ready back 1 cycle later.
REQ-035 Transposed line: octant 0, sx/sy (0,0)->(3,1) -> pixels (0,0)(0,1)(1,2)(1,3) in screen space.
REQ-036 Negative slope: octant 2, (0,5)->(4,3) -> pixels (0,5)(1,5)(2,4)(3,4)(4,3).
REQ-037 Degenerate cases, each a separate line:
- (7,9)->(7,9) -> single pixel (7,9) with pix_last=1.
- sx_1 < sx_0 -> single pixel (sx_0, sy_0).
REQ-038 Backpressure: toggle pix_ready 1/0 each cycle on the REQ-034 line -> identical pixel sequence, outputs stable while stalled, 12 cycles to completion.
REQ-039 Reset mid-line: assert rst after the 3rd pixel of the REQ-034 line -> pix_valid=0 at once; a new line accepted after deassertion starts from its own sx_0, sy_0.
